// File: rtl/buffer_pkg.sv
// Shared definitions for the ping/pong vector buffers: lane width, default
// depth and the bank-select type used by the core and its wrappers.
package buffer_pkg;

    localparam int unsigned LANE_W             = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 7;

    typedef logic bank_sel_t;

    localparam bank_sel_t BANK_PING = 1'b0;
    localparam bank_sel_t BANK_PONG = 1'b1;

endpackage

// File: rtl/act_buffer.sv
// Activation-side variant: TM lanes, output named a_vec.
module act_buffer
    import buffer_pkg::*;
#(
    parameter int unsigned TM         = 8,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [TM*LANE_W-1:0]    wdata,
    input  bank_sel_t               bank_sel_wr,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   k_idx,
    input  bank_sel_t               bank_sel_rd,
    output logic [TM*LANE_W-1:0]    a_vec
);

    pingpong_vec_buffer #(
        .LANES      (TM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .bank_sel_wr (bank_sel_wr),
        .rd_en       (rd_en),
        .k_idx       (k_idx),
        .bank_sel_rd (bank_sel_rd),
        .rd_vec      (a_vec)
    );

endmodule

// File: rtl/wgt_buffer.sv
// Weight-side variant: TN lanes, output named b_vec.
module wgt_buffer
    import buffer_pkg::*;
#(
    parameter int unsigned TN         = 8,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [TN*LANE_W-1:0]    wdata,
    input  bank_sel_t               bank_sel_wr,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   k_idx,
    input  bank_sel_t               bank_sel_rd,
    output logic [TN*LANE_W-1:0]    b_vec
);

    pingpong_vec_buffer #(
        .LANES      (TN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .bank_sel_wr (bank_sel_wr),
        .rd_en       (rd_en),
        .k_idx       (k_idx),
        .bank_sel_rd (bank_sel_rd),
        .rd_vec      (b_vec)
    );

endmodule

// File: rtl/pingpong_vec_buffer.sv
// Double-banked vector buffer core. The loader fills one bank while the
// compute pipeline reads the other, one vector per cycle. Only the read
// vector is registered; the banks themselves are never cleared.
module pingpong_vec_buffer
    import buffer_pkg::*;
#(
    parameter int unsigned LANES      = 8,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  bank_sel_t                 bank_sel_wr,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     k_idx,
    input  bank_sel_t                 bank_sel_rd,
    output logic [LANES*LANE_W-1:0]   rd_vec
);

    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned DEPTH  = 32'd1 << ADDR_WIDTH;

    logic [WORD_W-1:0] bank0_r [DEPTH];
    logic [WORD_W-1:0] bank1_r [DEPTH];

    logic              wr_bank0_s;
    logic              wr_bank1_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [WORD_W-1:0] rd_vec_r;

    // Steer the write enable to exactly one bank.
    always_comb begin
        wr_bank0_s = 1'b0;
        wr_bank1_s = 1'b0;
        case (bank_sel_wr)
            BANK_PING: wr_bank0_s = we;
            BANK_PONG: wr_bank1_s = we;
            default: begin
                wr_bank0_s = 1'b0;
                wr_bank1_s = 1'b0;
            end
        endcase
    end

    // Select the word at k_idx from the bank chosen for reading.
    always_comb begin
        rd_word_s = {WORD_W{1'b0}};
        case (bank_sel_rd)
            BANK_PING: rd_word_s = bank0_r[k_idx];
            BANK_PONG: rd_word_s = bank1_r[k_idx];
            default:   rd_word_s = {WORD_W{1'b0}};
        endcase
    end

    // Bank 0 write port; reset only blocks writes, contents survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (wr_bank0_s) begin
            bank0_r[waddr] <= wdata;
        end
    end

    // Bank 1 write port; reset only blocks writes, contents survive it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (wr_bank1_s) begin
            bank1_r[waddr] <= wdata;
        end
    end

    // Output register: samples the old word on a same-address collision
    // (read-before-write) and holds its value while rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vec_r <= {WORD_W{1'b0}};
        end else if (rd_en) begin
            rd_vec_r <= rd_word_s;
        end
    end

    assign rd_vec = rd_vec_r;

endmodule

// File: tb/tb_pingpong_vec_buffer.sv
// Bench for the ping/pong buffer core: two instances (activation and weight
// data, 4 lanes, 8 words per bank) share the control inputs. Directed table
// vectors, hand-written reset sequences and a random phase against a model.
module tb_pingpong_vec_buffer;

    localparam int unsigned LANES = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned W     = LANES * 8;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata_a;
    logic [W-1:0]  wdata_b;
    logic          bank_sel_wr;
    logic          rd_en;
    logic [AW-1:0] k_idx;
    logic          bank_sel_rd;
    logic [W-1:0]  a_vec;
    logic [W-1:0]  b_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: two banks of words plus the expected output value.
    logic [W-1:0] ma [2][8];
    logic [W-1:0] mb [2][8];
    logic [W-1:0] ea;
    logic [W-1:0] eb;

    typedef struct {
        logic         we;
        logic [2:0]   waddr;
        logic [7:0]   wa;
        logic [7:0]   wb;
        logic         bsw;
        logic         rd_en;
        logic [2:0]   k;
        logic         bsr;
        logic         chk;
        logic [31:0]  xa;
        logic [31:0]  xb;
        string        name;
    } vec_t;

    vec_t vq[$];

    pingpong_vec_buffer #(.LANES(LANES), .ADDR_WIDTH(AW)) u_act (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata_a),
        .bank_sel_wr(bank_sel_wr), .rd_en(rd_en), .k_idx(k_idx),
        .bank_sel_rd(bank_sel_rd), .rd_vec(a_vec)
    );

    pingpong_vec_buffer #(.LANES(LANES), .ADDR_WIDTH(AW)) u_wgt (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata_b),
        .bank_sel_wr(bank_sel_wr), .rd_en(rd_en), .k_idx(k_idx),
        .bank_sel_rd(bank_sel_rd), .rd_vec(b_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    function automatic vec_t mk(input logic w, input int wad, input int wa, input int wb,
                                input logic bsw, input logic re, input int k, input logic bsr,
                                input logic c, input logic [31:0] xa, input logic [31:0] xb,
                                input string nm);
        vec_t v;
        v.we = w; v.waddr = 3'(wad); v.wa = 8'(wa); v.wb = 8'(wb); v.bsw = bsw;
        v.rd_en = re; v.k = 3'(k); v.bsr = bsr; v.chk = c; v.xa = xa; v.xb = xb;
        v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock edge: model applies read-before-write semantics, then sample.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (rd_en) begin
                ea = ma[bank_sel_rd][k_idx];
                eb = mb[bank_sel_rd][k_idx];
            end
            if (we) begin
                ma[bank_sel_wr][waddr] = wdata_a;
                mb[bank_sel_wr][waddr] = wdata_b;
            end
        end else begin
            ea = '0;
            eb = '0;
        end
        #1;
    endtask

    initial begin
        vec_t v;
        logic [7:0] sa;
        logic [7:0] sb;

        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata_a = '0; wdata_b = '0;
        bank_sel_wr = 1'b0; rd_en = 1'b0; k_idx = '0; bank_sel_rd = 1'b0;
        ea = '0; eb = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_a", a_vec, 32'h0);
            check("reset_b", b_vec, 32'h0);
        end
        rst_n = 1'b1;

        // Fill bank 0; output stays at its reset value while not reading.
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1'b1, i, 8'hA0 + i, 8'hB0 + i, 1'b0, 1'b0, 0, 1'b0,
                            1'b1, 32'h0, 32'h0, "fill_wr"));
        // Single-cycle reads, each followed by an idle cycle with moving address.
        for (int i = 0; i < 8; i++) begin
            vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b1, i, 1'b0, 1'b1,
                            rep(8'(8'hA0 + i)), rep(8'(8'hB0 + i)), "fill_rd"));
            vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 7 - i, 1'b1, 1'b1,
                            rep(8'(8'hA0 + i)), rep(8'(8'hB0 + i)), "fill_hold"));
        end
        // Fill bank 1 while bank 0 is being read.
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1'b1, i, 8'hC0 + i, 8'hD0 + i, 1'b1, 1'b1, i, 1'b0, 1'b1,
                            rep(8'(8'hA0 + i)), rep(8'(8'hB0 + i)), "swap_wr"));
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b1, i, 1'b1, 1'b1,
                            rep(8'(8'hC0 + i)), rep(8'(8'hD0 + i)), "swap_rd1"));
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b1, i, 1'b0, 1'b1,
                            rep(8'(8'hA0 + i)), rep(8'(8'hB0 + i)), "swap_rd0"));
        // Hold with rd_en low while address and bank select wander.
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b0, i * 3, 1'(i), 1'b1,
                            rep(8'hA7), rep(8'hB7), "hold"));
        // Same-edge read and write of bank 0 address 3.
        vq.push_back(mk(1'b1, 3, 8'h11, 8'h11, 1'b0, 1'b1, 3, 1'b0, 1'b1,
                        rep(8'hA3), rep(8'hB3), "collide_old"));
        vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1,
                        rep(8'h11), rep(8'h11), "collide_new"));
        // Back-to-back streaming of bank 0.
        for (int i = 0; i < 8; i++) begin
            sa = (i == 3) ? 8'h11 : 8'(8'hA0 + i);
            sb = (i == 3) ? 8'h11 : 8'(8'hB0 + i);
            vq.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b1, i, 1'b0, 1'b1,
                            rep(sa), rep(sb), "stream"));
        end

        foreach (vq[n]) begin
            v = vq[n];
            we = v.we; waddr = v.waddr; wdata_a = rep(v.wa); wdata_b = rep(v.wb);
            bank_sel_wr = v.bsw; rd_en = v.rd_en; k_idx = v.k; bank_sel_rd = v.bsr;
            tick();
            if (v.chk) begin
                check({v.name, "_a"}, a_vec, v.xa);
                check({v.name, "_b"}, b_vec, v.xb);
            end
        end

        // Mid-run reset: valid read, then asynchronous clear between edges.
        we = 1'b0; rd_en = 1'b1; k_idx = 3'd5; bank_sel_rd = 1'b1;
        tick();
        check("pre_rst_a", a_vec, rep(8'hC5));
        #2;
        rst_n = 1'b0;
        ea = '0; eb = '0;
        #1;
        check("rst_async_a", a_vec, 32'h0);
        check("rst_async_b", b_vec, 32'h0);
        // Write and read attempted during reset are ignored.
        we = 1'b1; waddr = 3'd5; bank_sel_wr = 1'b0; wdata_a = rep(8'hEE); wdata_b = rep(8'hEE);
        rd_en = 1'b1; k_idx = 3'd5; bank_sel_rd = 1'b0;
        tick();
        check("rst_hold_a", a_vec, 32'h0);
        check("rst_hold_b", b_vec, 32'h0);
        rst_n = 1'b1;
        we = 1'b0;
        tick();
        check("rst_mem_kept_a", a_vec, rep(8'hA5));
        check("rst_mem_kept_b", b_vec, rep(8'hB5));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(1, 0));
            waddr = 3'($urandom_range(7, 0));
            wdata_a = 32'($urandom);
            wdata_b = 32'($urandom);
            bank_sel_wr = 1'($urandom_range(1, 0));
            rd_en = 1'($urandom_range(1, 0));
            k_idx = 3'($urandom_range(7, 0));
            bank_sel_rd = 1'($urandom_range(1, 0));
            tick();
            check("rand_a", a_vec, ea);
            check("rand_b", b_vec, eb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
